// File: rtl/vocie_change_rd_ctrl_if.sv
// rtl/vocie_change_rd_ctrl_if.sv - FIFO read port and PCM output bundle for the voice-change read controller
interface vocie_change_rd_ctrl_if #(
  parameter int c_DEPTH_WIDTH = 10,
  parameter int c_DATA_WIDTH  = 32
);
  logic                      fifo_rd_en;
  logic [c_DATA_WIDTH-1:0]   fifo_rd_data;
  logic                      fifo_rd_empty;
  logic [c_DEPTH_WIDTH:0]    fifo_rd_water_level;
  logic [c_DATA_WIDTH/2-1:0] pcm_left;
  logic [c_DATA_WIDTH/2-1:0] pcm_right;
  logic                      pcm_valid;

  modport master (
    output fifo_rd_en,
    input  fifo_rd_data,
    input  fifo_rd_empty,
    input  fifo_rd_water_level,
    output pcm_left,
    output pcm_right,
    output pcm_valid
  );

  modport slave (
    input  fifo_rd_en,
    output fifo_rd_data,
    output fifo_rd_empty,
    output fifo_rd_water_level,
    input  pcm_left,
    input  pcm_right,
    input  pcm_valid
  );
endinterface

// File: rtl/vocie_change_rd_ctrl.sv
// rtl/vocie_change_rd_ctrl.sv - voice-change FIFO read controller: pre-fill, per-tick pop, stereo unpack
// Silence is substituted on underrun and the controller falls back to pre-fill.
module vocie_change_rd_ctrl #(
  parameter int c_DEPTH_WIDTH = 10,
  parameter int c_DATA_WIDTH  = 32,
  parameter int c_START_LEVEL = 256,
  parameter int c_CNT_WIDTH   = 16
) (
  input  logic                   rd_clk,
  input  logic                   rd_rst,
  input  logic                   enable,
  input  logic                   sample_tick,
  vocie_change_rd_ctrl_if.master bus,
  output logic                   playing,
  output logic                   underrun,
  output logic [c_CNT_WIDTH-1:0] underrun_cnt
);
  localparam int HALF = c_DATA_WIDTH / 2;
  localparam logic [c_DEPTH_WIDTH:0] START_LEVEL = (c_DEPTH_WIDTH + 1)'(c_START_LEVEL);

  typedef enum logic [1:0] {IDLE, PREFILL, PLAY} state_t;

  state_t state;
  logic   busy;
  logic   capture;
  logic   discard;
  logic   tick_ok;
  logic   level_ok;

  assign tick_ok  = sample_tick && !busy;
  assign level_ok = bus.fifo_rd_water_level >= START_LEVEL;

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      state          <= IDLE;
      busy           <= 1'b0;
      capture        <= 1'b0;
      discard        <= 1'b0;
      bus.fifo_rd_en <= 1'b0;
      bus.pcm_left   <= '0;
      bus.pcm_right  <= '0;
      bus.pcm_valid  <= 1'b0;
      playing        <= 1'b0;
      underrun       <= 1'b0;
      underrun_cnt   <= '0;
    end else begin
      bus.fifo_rd_en <= 1'b0;
      bus.pcm_valid  <= 1'b0;
      underrun       <= 1'b0;
      // FIFO has no output register: data is on the bus the cycle after the pop
      capture        <= bus.fifo_rd_en;

      if (capture) begin
        busy    <= 1'b0;
        discard <= 1'b0;
        if (!discard && enable) begin
          bus.pcm_valid <= 1'b1;
          bus.pcm_left  <= bus.fifo_rd_data[c_DATA_WIDTH-1:HALF];
          bus.pcm_right <= bus.fifo_rd_data[HALF-1:0];
        end
      end else if (busy && !enable) begin
        discard <= 1'b1;
      end

      if (!enable) begin
        state   <= IDLE;
        playing <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            state <= PREFILL;
          end
          PREFILL: begin
            if (tick_ok) begin
              bus.pcm_valid <= 1'b1;
              bus.pcm_left  <= '0;
              bus.pcm_right <= '0;
            end
            if (level_ok) begin
              state   <= PLAY;
              playing <= 1'b1;
            end
          end
          PLAY: begin
            if (tick_ok) begin
              if (bus.fifo_rd_empty) begin
                bus.pcm_valid <= 1'b1;
                bus.pcm_left  <= '0;
                bus.pcm_right <= '0;
                underrun      <= 1'b1;
                if (underrun_cnt != '1) underrun_cnt <= underrun_cnt + c_CNT_WIDTH'(1);
                state   <= PREFILL;
                playing <= 1'b0;
              end else begin
                bus.fifo_rd_en <= 1'b1;
                busy           <= 1'b1;
              end
            end
          end
          default: begin
            state   <= IDLE;
            playing <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_vocie_change_rd_ctrl.sv
// tb/tb_vocie_change_rd_ctrl.sv - directed self-checking bench for vocie_change_rd_ctrl
module tb_vocie_change_rd_ctrl;
  logic        rd_clk = 1'b0;
  logic        rd_rst;
  logic        enable;
  logic        enable2;
  logic        sample_tick;
  logic        playing, underrun, playing2, underrun2;
  logic [15:0] underrun_cnt;
  logic [2:0]  underrun_cnt2;
  logic [31:0] next_word;

  int n_checks = 0;
  int n_fail   = 0;
  int en_cnt   = 0;
  int valid_cnt = 0;
  int und2_cnt = 0;
  int e0, v0;

  vocie_change_rd_ctrl_if #(.c_DEPTH_WIDTH(10), .c_DATA_WIDTH(32)) bus ();
  vocie_change_rd_ctrl_if #(.c_DEPTH_WIDTH(10), .c_DATA_WIDTH(32)) bus2 ();

  vocie_change_rd_ctrl #(
    .c_DEPTH_WIDTH(10), .c_DATA_WIDTH(32), .c_START_LEVEL(256), .c_CNT_WIDTH(16)
  ) dut (
    .rd_clk(rd_clk), .rd_rst(rd_rst), .enable(enable), .sample_tick(sample_tick),
    .bus(bus), .playing(playing), .underrun(underrun), .underrun_cnt(underrun_cnt)
  );

  vocie_change_rd_ctrl #(
    .c_DEPTH_WIDTH(10), .c_DATA_WIDTH(32), .c_START_LEVEL(1), .c_CNT_WIDTH(3)
  ) dut_sat (
    .rd_clk(rd_clk), .rd_rst(rd_rst), .enable(enable2), .sample_tick(sample_tick),
    .bus(bus2), .playing(playing2), .underrun(underrun2), .underrun_cnt(underrun_cnt2)
  );

  always #5 rd_clk = ~rd_clk;

  // FIFO model: popped word appears on the data bus the cycle after fifo_rd_en
  always @(posedge rd_clk) if (bus.fifo_rd_en) bus.fifo_rd_data <= next_word;
  always @(posedge rd_clk) if (bus2.fifo_rd_en) bus2.fifo_rd_data <= 32'h0;

  always @(negedge rd_clk) begin
    if (bus.fifo_rd_en) en_cnt++;
    if (bus.pcm_valid) valid_cnt++;
    if (underrun2) und2_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge rd_clk);
    #1;
  endtask

  task automatic tick();
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rd_rst = 1'b1; enable = 1'b0; enable2 = 1'b0; sample_tick = 1'b0; next_word = '0;
    bus.fifo_rd_data = '0; bus.fifo_rd_empty = 1'b1; bus.fifo_rd_water_level = '0;
    bus2.fifo_rd_data = '0; bus2.fifo_rd_empty = 1'b1; bus2.fifo_rd_water_level = 11'd1;
    step(); step();
    rd_rst = 1'b0;

    check("rst_rd_en", bus.fifo_rd_en, 0);
    check("rst_valid", bus.pcm_valid, 0);
    check("rst_left", bus.pcm_left, 0);
    check("rst_playing", playing, 0);
    check("rst_underrun", underrun, 0);
    check("rst_cnt", underrun_cnt, 0);

    // idle ignores ticks
    tick();
    check("idle_tick_valid", bus.pcm_valid, 0);

    // pre-fill with rising level
    enable = 1'b1;
    step();
    for (int i = 0; i < 8; i++) begin
      bus.fifo_rd_water_level = 11'(i * 32);
      tick();
      check("prefill_valid", bus.pcm_valid, 1);
      check("prefill_left", bus.pcm_left, 0);
      check("prefill_playing", playing, 0);
      step();
      check("prefill_no_tick", bus.pcm_valid, 0);
      repeat (6) step();
    end
    check("prefill_no_rd", en_cnt, 0);
    bus.fifo_rd_water_level = 11'd256;
    tick();
    check("edge_tick_silence", bus.pcm_valid, 1);
    check("edge_no_rd", bus.fifo_rd_en, 0);
    check("edge_playing", playing, 1);

    // steady play
    bus.fifo_rd_empty = 1'b0;
    next_word = 32'hAAAA5555;
    repeat (3) step();
    tick();
    check("p1_rd_en", bus.fifo_rd_en, 1);
    check("p1_valid_t1", bus.pcm_valid, 0);
    step();
    check("p1_rd_en_t2", bus.fifo_rd_en, 0);
    check("p1_valid_t2", bus.pcm_valid, 0);
    step();
    check("p1_valid_t3", bus.pcm_valid, 1);
    check("p1_left", bus.pcm_left, 16'hAAAA);
    check("p1_right", bus.pcm_right, 16'h5555);
    repeat (5) step();
    next_word = 32'h12348765;
    tick();
    check("p2_rd_en", bus.fifo_rd_en, 1);
    step(); step();
    check("p2_valid", bus.pcm_valid, 1);
    check("p2_left", bus.pcm_left, 16'h1234);
    check("p2_right", bus.pcm_right, 16'h8765);

    // underrun
    bus.fifo_rd_empty = 1'b1;
    repeat (2) step();
    tick();
    bus.fifo_rd_water_level = 11'd100;
    check("ur_rd_en", bus.fifo_rd_en, 0);
    check("ur_valid", bus.pcm_valid, 1);
    check("ur_pulse", underrun, 1);
    check("ur_left", bus.pcm_left, 0);
    check("ur_right", bus.pcm_right, 0);
    check("ur_cnt", underrun_cnt, 1);
    check("ur_playing", playing, 0);
    step();
    check("ur_pulse_end", underrun, 0);
    repeat (5) step();
    tick();
    check("ur_silence_valid", bus.pcm_valid, 1);
    check("ur_silence_no_ur", underrun, 0);
    check("ur_silence_rd_en", bus.fifo_rd_en, 0);
    bus.fifo_rd_water_level = 11'd256;
    step();
    check("ur_replay", playing, 1);

    // ticks two cycles apart: the second is dropped
    bus.fifo_rd_empty = 1'b0;
    next_word = 32'h0BADF00D;
    repeat (2) step();
    e0 = en_cnt; v0 = valid_cnt;
    tick();
    step();
    tick();
    check("sp_valid", bus.pcm_valid, 1);
    check("sp_left", bus.pcm_left, 16'h0BAD);
    check("sp_right", bus.pcm_right, 16'hF00D);
    repeat (4) step();
    check("sp_one_rd", en_cnt - e0, 1);
    check("sp_one_valid", valid_cnt - v0, 1);

    // disable while a read is in flight
    next_word = 32'hCAFEBEEF;
    e0 = en_cnt; v0 = valid_cnt;
    tick();
    check("dis_rd_en", bus.fifo_rd_en, 1);
    enable = 1'b0;
    step();
    check("dis_playing", playing, 0);
    step();
    check("dis_no_valid", bus.pcm_valid, 0);
    check("dis_hold_left", bus.pcm_left, 16'h0BAD);
    repeat (2) step();
    tick();
    repeat (4) step();
    check("dis_pop_done", en_cnt - e0, 1);
    check("dis_valid_none", valid_cnt - v0, 0);
    check("dis_hold_right", bus.pcm_right, 16'hF00D);
    check("dis_cnt_kept", underrun_cnt, 1);

    // reset in the middle of a read
    enable = 1'b1;
    step(); step();
    check("mr_playing", playing, 1);
    tick();
    check("mr_rd_en", bus.fifo_rd_en, 1);
    step();
    rd_rst = 1'b1;
    #1;
    check("mr_rd_en0", bus.fifo_rd_en, 0);
    check("mr_playing0", playing, 0);
    check("mr_cnt0", underrun_cnt, 0);
    check("mr_left0", bus.pcm_left, 0);
    check("mr_valid0", bus.pcm_valid, 0);
    v0 = valid_cnt;
    step(); step();
    rd_rst = 1'b0;
    enable = 1'b0;
    step(); step();
    check("mr_no_valid", valid_cnt - v0, 0);

    // saturation on a 3-bit counter
    enable2 = 1'b1;
    step(); step();
    for (int i = 1; i <= 9; i++) begin
      tick();
      check("sat_pulse", underrun2, 1);
      check("sat_cnt", underrun_cnt2, (i < 7) ? i : 7);
      step();
    end
    check("sat_events", und2_cnt, 9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
